vec_fp_lane_sequencer: RTL and testbench

- Serialises one 4-lane vector floating-point operation onto a single shared, pipelined, scalar FP ALU, one lane per cycle.
- Collects the in-order results and returns the assembled 128-bit vector with a valid/ready handshake.
- Sits between vector decode/issue and the shared FP ALU; masked lanes bypass the ALU and keep their old destination value.

---
 rtl/vec_fp_lane_sequencer_pkg.sv | 38 +++
 rtl/vec_fp_lane_sequencer_prio_enc.sv | 25 ++
 rtl/vec_fp_lane_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vec_fp_lane_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_fp_lane_sequencer_pkg.sv
// Shared constants, lane typedefs and helpers for the vector FP lane sequencer.
package vec_fp_lane_sequencer_pkg;

  localparam int LANES    = 4;
  localparam int LANE_W   = 32;
  localparam int OP_W     = 4;
  localparam int MAX_WAIT = 64;

  localparam int VEC_W  = LANES * LANE_W;
  localparam int IDX_W  = $clog2(LANES);
  localparam int CNT_W  = $clog2(LANES) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef logic [LANES-1:0]  lane_mask_t;
  typedef logic [IDX_W-1:0]  lane_idx_t;
  typedef logic [LANE_W-1:0] lane_data_t;
  typedef logic [CNT_W-1:0]  lane_cnt_t;
  typedef logic [WAIT_W-1:0] wait_cnt_t;

  localparam wait_cnt_t WAIT_MAX = wait_cnt_t'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic lane_cnt_t lane_popcount(input lane_mask_t m);
    lane_cnt_t c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      c = c + lane_cnt_t'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vec_fp_lane_sequencer_prio_enc.sv
// Find-first-set lane at or above a start index; start values >= LANES find nothing.
module vec_lane_prio_enc
  import vec_fp_lane_sequencer_pkg::*;
(
  input  lane_mask_t mask_i,
  input  lane_cnt_t  start_i,
  output lane_idx_t  idx_o,
  output logic       found_o
);

  // Descending scan so the lowest qualifying lane is the last one written.
  always_comb begin
    idx_o   = {IDX_W{1'b0}};
    found_o = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i] && (lane_cnt_t'(i) >= start_i)) begin
        idx_o   = lane_idx_t'(i);
        found_o = 1'b1;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/vec_fp_lane_sequencer.sv
// Serialises one masked 4-lane vector FP op onto a shared pipelined scalar FP ALU
// and reassembles the in-order results into a 128-bit response.
module vec_fp_lane_sequencer
  import vec_fp_lane_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [VEC_W-1:0]  req_a,
  input  logic [VEC_W-1:0]  req_b,
  input  logic [VEC_W-1:0]  req_old,
  input  logic [LANES-1:0]  req_mask,
  output logic              fa_valid,
  input  logic              fa_ready,
  output logic [OP_W-1:0]   fa_op,
  output logic [LANE_W-1:0] fa_a,
  output logic [LANE_W-1:0] fa_b,
  input  logic              fa_res_valid,
  input  logic [LANE_W-1:0] fa_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [VEC_W-1:0]  rsp_data,
  output logic              timeout_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [VEC_W-1:0]  a_q, b_q;
  logic [VEC_W-1:0]  res_q, res_d;
  lane_mask_t        mask_q;
  lane_cnt_t         iss_from_q, iss_from_d;
  lane_cnt_t         wr_from_q, wr_from_d;
  lane_cnt_t         iss_cnt_q, iss_cnt_d;
  lane_cnt_t         rcv_cnt_q, rcv_cnt_d;
  wait_cnt_t         wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              req_ready_q, fa_valid_q, rsp_valid_q, busy_q;

  lane_idx_t         iss_idx_s, wr_idx_s;
  logic              iss_found_s, wr_found_s;
  lane_cnt_t         act_cnt_s;
  logic              iss_fire_s, res_live_s, res_acc_s, res_spur_s;

  vec_lane_prio_enc u_iss_enc (
    .mask_i  (mask_q),
    .start_i (iss_from_q),
    .idx_o   (iss_idx_s),
    .found_o (iss_found_s)
  );

  vec_lane_prio_enc u_wr_enc (
    .mask_i  (mask_q),
    .start_i (wr_from_q),
    .idx_o   (wr_idx_s),
    .found_o (wr_found_s)
  );

  assign act_cnt_s  = lane_popcount(mask_q);
  assign iss_fire_s = fa_valid_q && fa_ready && iss_found_s;
  assign res_live_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  // A result is only legal when some issued lane is still waiting for it.
  assign res_acc_s  = fa_res_valid && res_live_s && (rcv_cnt_q < iss_cnt_q) && wr_found_s;
  assign res_spur_s = fa_res_valid && !res_acc_s;

  assign req_ready   = req_ready_q;
  assign fa_valid    = fa_valid_q;
  assign fa_op       = op_q;
  assign fa_a        = a_q[iss_idx_s*LANE_W +: LANE_W];
  assign fa_b        = b_q[iss_idx_s*LANE_W +: LANE_W];
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = res_q;
  assign timeout_err = timeout_q;
  assign busy        = busy_q;

  // Next-state, pointer, counter and result-register update.
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    iss_from_d = iss_from_q;
    wr_from_d  = wr_from_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    wait_d     = wait_q;
    timeout_d  = timeout_q | res_spur_s;

    if (res_acc_s) begin
      res_d[wr_idx_s*LANE_W +: LANE_W] = fa_res;
      wr_from_d = lane_cnt_t'(wr_idx_s) + lane_cnt_t'(1'b1);
      rcv_cnt_d = rcv_cnt_q + lane_cnt_t'(1'b1);
    end else begin
      rcv_cnt_d = rcv_cnt_q;
    end

    if (iss_fire_s) begin
      iss_from_d = lane_cnt_t'(iss_idx_s) + lane_cnt_t'(1'b1);
      iss_cnt_d  = iss_cnt_q + lane_cnt_t'(1'b1);
    end else begin
      iss_cnt_d = iss_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d    = (req_mask == {LANES{1'b0}}) ? ST_DONE : ST_ISSUE;
          res_d      = req_old;
          iss_from_d = {CNT_W{1'b0}};
          wr_from_d  = {CNT_W{1'b0}};
          iss_cnt_d  = {CNT_W{1'b0}};
          rcv_cnt_d  = {CNT_W{1'b0}};
          wait_d     = {WAIT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (iss_cnt_d == act_cnt_s) begin
          if (rcv_cnt_d == act_cnt_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            wait_d  = {WAIT_W{1'b0}};
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (rcv_cnt_d == act_cnt_s) begin
          state_d = ST_DONE;
        end else begin
          if (fa_res_valid) begin
            wait_d = {WAIT_W{1'b0}};
          end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + wait_cnt_t'(1'b1);
          end else begin
            wait_d = wait_q;
          end
          // Give up on the missing lanes; they keep the prior destination value.
          if (wait_d == WAIT_MAX) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, captured request and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= {OP_W{1'b0}};
      a_q         <= {VEC_W{1'b0}};
      b_q         <= {VEC_W{1'b0}};
      res_q       <= {VEC_W{1'b0}};
      mask_q      <= {LANES{1'b0}};
      iss_from_q  <= {CNT_W{1'b0}};
      wr_from_q   <= {CNT_W{1'b0}};
      iss_cnt_q   <= {CNT_W{1'b0}};
      rcv_cnt_q   <= {CNT_W{1'b0}};
      wait_q      <= {WAIT_W{1'b0}};
      timeout_q   <= 1'b0;
      req_ready_q <= 1'b1;
      fa_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      iss_from_q <= iss_from_d;
      wr_from_q  <= wr_from_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
      if ((state_q == ST_IDLE) && req_valid) begin
        op_q   <= req_op;
        a_q    <= req_a;
        b_q    <= req_b;
        mask_q <= req_mask;
      end else begin
        mask_q <= mask_q;
      end
      req_ready_q <= (state_d == ST_IDLE);
      fa_valid_q  <= (state_d == ST_ISSUE);
      rsp_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_vec_fp_lane_sequencer.sv
// Directed bench for vec_fp_lane_sequencer with a latency-3 FP-add ALU model.
module tb_vec_fp_lane_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [3:0]   req_op;
  logic [127:0] req_a, req_b, req_old;
  logic [3:0]   req_mask;
  logic         fa_valid, fa_ready;
  logic [3:0]   fa_op;
  logic [31:0]  fa_a, fa_b;
  logic         fa_res_valid;
  logic [31:0]  fa_res;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         timeout_err, busy;

  int n_cmp, n_bad;
  int alu_iss = 0;
  int alu_ret = 0;
  int alu_limit;

  logic [31:0]  pipe_d [3];
  logic         pipe_v [3];

  vec_fp_lane_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_old(req_old), .req_mask(req_mask),
    .fa_valid(fa_valid), .fa_ready(fa_ready), .fa_op(fa_op), .fa_a(fa_a), .fa_b(fa_b),
    .fa_res_valid(fa_res_valid), .fa_res(fa_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic s;
    int   e;
    real  m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  // ALU model: result of an issue seen in cycle c is presented during cycle c+3.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe_v[k] = 1'b0;
      fa_res_valid = 1'b0;
      fa_res       = 32'd0;
    end else begin
      fa_res_valid = pipe_v[2] && (alu_ret < alu_limit);
      fa_res       = pipe_d[2];
      if (pipe_v[2]) alu_ret++;
      pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
      pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
      pipe_v[0] = fa_valid && fa_ready;
      pipe_d[0] = r2sp(sp2r(fa_a) + sp2r(fa_b));
      if (pipe_v[0]) alu_iss++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max_cyc) begin
      step();
      cyc++;
    end
  endtask

  logic [127:0] a_v, one_v, two_v;
  int i0, cyc;

  initial begin
    n_cmp = 0; n_bad = 0; alu_limit = 1000000;
    a_v   = 128'h40800000_40400000_40000000_3F800000;  // {4.0,3.0,2.0,1.0}
    one_v = {4{32'h3F800000}};
    two_v = {4{32'h40000000}};
    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = '0; req_b = '0;
    req_old = '0; req_mask = 4'h0; fa_ready = 1'b1; rsp_ready = 1'b1;
    repeat (2) step();
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_fa_valid", 128'(fa_valid), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_timeout", 128'(timeout_err), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    rst = 1'b0;
    step();

    // Test 1: full mask, exact latency with L=3
    req_op = 4'h1; req_a = a_v; req_b = one_v; req_old = '0; req_mask = 4'hF; req_valid = 1'b1;
    i0 = alu_iss;
    step();
    req_valid = 1'b0;
    chk("t1_req_ready", 128'(req_ready), 128'd0);
    chk("t1_busy", 128'(busy), 128'd1);
    chk("t1_fa_op", 128'(fa_op), 128'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_fa_valid_c%0d", i + 1), 128'(fa_valid), 128'd1);
      chk($sformatf("t1_fa_a_c%0d", i + 1), 128'(fa_a), 128'(a_v[i*32 +: 32]));
      step();
    end
    for (int i = 5; i < 8; i++) begin
      chk($sformatf("t1_fa_idle_c%0d", i), 128'(fa_valid), 128'd0);
      chk($sformatf("t1_rsp_early_c%0d", i), 128'(rsp_valid), 128'd0);
      step();
    end
    chk("t1_rsp_valid_c8", 128'(rsp_valid), 128'd1);
    chk("t1_rsp_data", rsp_data, 128'h40A00000_40800000_40400000_40000000);
    chk("t1_issues", 128'(alu_iss - i0), 128'd4);
    step();
    chk("t1_back_idle", 128'(req_ready), 128'd1);

    // Test 2: sparse mask 1010
    req_old = {4{32'hDEADBEEF}}; req_mask = 4'b1010; req_valid = 1'b1;
    i0 = alu_iss;
    step();
    req_valid = 1'b0;
    chk("t2_fa_a_lane1", 128'(fa_a), 128'h40000000);
    step();
    chk("t2_fa_a_lane3", 128'(fa_a), 128'h40800000);
    step();
    chk("t2_fa_idle", 128'(fa_valid), 128'd0);
    wait_rsp(20, cyc);
    chk("t2_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("t2_latency", 128'(cyc), 128'd3);
    chk("t2_rsp_data", rsp_data, 128'h40A00000_DEADBEEF_40400000_DEADBEEF);
    chk("t2_issues", 128'(alu_iss - i0), 128'd2);
    step();

    // Test 3: empty mask bypasses the ALU
    req_old = 128'h01234567_89ABCDEF_FEDCBA98_76543210; req_mask = 4'b0000; req_valid = 1'b1;
    i0 = alu_iss;
    step();
    req_valid = 1'b0;
    chk("t3_rsp_valid_c1", 128'(rsp_valid), 128'd1);
    chk("t3_fa_valid", 128'(fa_valid), 128'd0);
    chk("t3_rsp_data", rsp_data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    chk("t3_issues", 128'(alu_iss - i0), 128'd0);
    step();

    // Test 4: fa_ready stall in cycles 2-4, response back-pressure
    req_b = two_v; req_old = '0; req_mask = 4'hF; rsp_ready = 1'b0; req_valid = 1'b1;
    i0 = alu_iss;
    step();
    req_valid = 1'b0;
    chk("t4_fa_a_c1", 128'(fa_a), 128'h3F800000);
    step();
    fa_ready = 1'b0;
    for (int c = 2; c < 5; c++) begin
      chk($sformatf("t4_hold_valid_c%0d", c), 128'(fa_valid), 128'd1);
      chk($sformatf("t4_hold_a_c%0d", c), 128'(fa_a), 128'h40000000);
      chk($sformatf("t4_hold_b_c%0d", c), 128'(fa_b), 128'h40000000);
      step();
    end
    fa_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t4_fa_a_lane%0d", i), 128'(fa_a), 128'(a_v[i*32 +: 32]));
      step();
    end
    chk("t4_fa_idle", 128'(fa_valid), 128'd0);
    wait_rsp(20, cyc);
    chk("t4_latency", 128'(cyc), 128'd3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_rsp_hold_%0d", k), 128'(rsp_valid), 128'd1);
      chk($sformatf("t4_rsp_data_%0d", k), rsp_data, 128'h40C00000_40A00000_40800000_40400000);
      step();
    end
    chk("t4_issues", 128'(alu_iss - i0), 128'd4);
    rsp_ready = 1'b1;
    step();
    chk("t4_rsp_drop", 128'(rsp_valid), 128'd0);
    chk("t4_req_ready", 128'(req_ready), 128'd1);

    // Test 5: ALU drops the last of three results
    req_b = one_v; req_old = 128'h11111111_22222222_33333333_44444444; req_mask = 4'b0111;
    rsp_ready = 1'b0; alu_limit = alu_ret + 2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (40) step();
    chk("t5_no_early_timeout", 128'(timeout_err), 128'd0);
    chk("t5_still_busy", 128'(busy), 128'd1);
    chk("t5_no_early_rsp", 128'(rsp_valid), 128'd0);
    wait_rsp(200, cyc);
    chk("t5_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("t5_timeout", 128'(timeout_err), 128'd1);
    chk("t5_rsp_data", rsp_data, 128'h11111111_22222222_40400000_40000000);
    alu_limit = 1000000;
    rsp_ready = 1'b1;
    step();
    chk("t5_idle", 128'(req_ready), 128'd1);
    chk("t5_not_busy", 128'(busy), 128'd0);
    chk("t5_sticky", 128'(timeout_err), 128'd1);

    // Test 6: reset in the middle of issuing
    req_b = one_v; req_old = '0; req_mask = 4'hF; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("t6_pre_fa_valid", 128'(fa_valid), 128'd1);
    rst = 1'b1;
    #1;
    chk("t6_fa_valid", 128'(fa_valid), 128'd0);
    chk("t6_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_req_ready", 128'(req_ready), 128'd1);
    chk("t6_timeout_clr", 128'(timeout_err), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    i0 = alu_iss;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    wait_rsp(30, cyc);
    chk("t6_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("t6_rsp_data", rsp_data, 128'h40A00000_40800000_40400000_40000000);
    chk("t6_issues", 128'(alu_iss - i0), 128'd4);
    chk("t6_timeout", 128'(timeout_err), 128'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
